// File: rtl/aes_round_sequencer.sv
// Round/key-schedule sequencer for an iterative AES-128/192/256 datapath, encrypt and decrypt.
// state  | meaning
// IDLE   | waiting for a job; load is a combinational strobe on the acceptance edge
// KEYEXP | decrypt only: forward-expand the key schedule up to the final round key
// INIT   | initial AddRoundKey (round 0 for encrypt, round Nr for decrypt)
// ROUND  | one full/inverse round per cycle; last cycle omits (Inv)MixColumns
// DONE   | result held valid until the consumer takes it
module aes_round_sequencer #(
   parameter int NR_128 = 10,
   parameter int NR_192 = 12,
   parameter int NR_256 = 14,
   parameter int RIDX_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic              mode,
   input  logic [1:0]        key_size,
   input  logic              abort,
   output logic              load,
   output logic              key_step,
   output logic              key_dir,
   output logic              init_ark,
   output logic              round_en,
   output logic              last_round,
   output logic              inv,
   output logic [RIDX_W-1:0] round_idx,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_KEYEXP,
      S_INIT,
      S_ROUND,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [RIDX_W-1:0] idx_q, idx_d;
   logic [RIDX_W-1:0] rem_q, rem_d;
   logic [RIDX_W-1:0] nr_q, nr_d;
   logic [RIDX_W-1:0] nr_sel;
   logic              inv_q, inv_d;
   logic              err_q, err_d;
   logic              key_legal;
   logic              rem_last;

   always_comb begin
      key_legal = 1'b1;
      case (key_size)
         2'b00:   nr_sel = RIDX_W'(NR_128);
         2'b01:   nr_sel = RIDX_W'(NR_192);
         2'b10:   nr_sel = RIDX_W'(NR_256);
         default: begin
            nr_sel    = RIDX_W'(NR_128);
            key_legal = 1'b0;
         end
      endcase
   end

   // rem_q is the down-counter for KEYEXP and ROUND; terminal count at 1
   assign rem_last = (rem_q == RIDX_W'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         rem_q   <= '0;
         nr_q    <= '0;
         inv_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         nr_q    <= nr_d;
         inv_q   <= inv_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      rem_d       = rem_q;
      nr_d        = nr_q;
      inv_d       = inv_q;
      err_d       = 1'b0;
      start_ready = rst_n && (state_q == S_IDLE);
      load        = 1'b0;
      key_step    = 1'b0;
      key_dir     = 1'b0;
      init_ark    = 1'b0;
      round_en    = 1'b0;
      last_round  = 1'b0;
      busy        = (state_q != S_IDLE);
      out_valid   = 1'b0;
      inv         = inv_q;
      round_idx   = idx_q;
      err         = err_q;

      case (state_q)
         S_IDLE: begin
            idx_d = '0;
            if (start_valid && start_ready) begin
               if (key_legal) begin
                  load  = 1'b1;
                  nr_d  = nr_sel;
                  rem_d = nr_sel;
                  inv_d = mode;
                  if (mode) begin
                     state_d = S_KEYEXP;
                     idx_d   = RIDX_W'(1);
                  end else begin
                     state_d = S_INIT;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_KEYEXP: begin
            key_step = 1'b1;
            if (rem_last) begin
               state_d = S_INIT;
            end else begin
               rem_d = rem_q - RIDX_W'(1);
               idx_d = idx_q + RIDX_W'(1);
            end
         end
         S_INIT: begin
            init_ark = 1'b1;
            key_dir  = inv_q;
            state_d  = S_ROUND;
            rem_d    = nr_q;
            idx_d    = inv_q ? nr_q - RIDX_W'(1) : RIDX_W'(1);
         end
         S_ROUND: begin
            round_en   = 1'b1;
            key_step   = 1'b1;
            key_dir    = inv_q;
            last_round = rem_last;
            if (rem_last) begin
               state_d = S_DONE;
            end else begin
               rem_d = rem_q - RIDX_W'(1);
               idx_d = inv_q ? idx_q - RIDX_W'(1) : idx_q + RIDX_W'(1);
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            key_dir   = inv_q;
            if (out_ready) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase

      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         idx_d   = '0;
      end

      // Outputs read as zero for every cycle reset is asserted, not just after the first edge
      if (!rst_n) begin
         load       = 1'b0;
         key_step   = 1'b0;
         key_dir    = 1'b0;
         init_ark   = 1'b0;
         round_en   = 1'b0;
         last_round = 1'b0;
         busy       = 1'b0;
         out_valid  = 1'b0;
         inv        = 1'b0;
         round_idx  = '0;
         err        = 1'b0;
      end
   end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: per-cycle check against a job-offset model plus directed latency pins.
module tb_aes_round_sequencer;
   localparam int RIDX_W = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start_valid = 1'b0;
   logic              mode = 1'b0;
   logic [1:0]        key_size = 2'b00;
   logic              abort = 1'b0;
   logic              out_ready = 1'b0;
   logic              start_ready, load, key_step, key_dir, init_ark, round_en;
   logic              last_round, inv, busy, out_valid, err;
   logic [RIDX_W-1:0] round_idx;

   aes_round_sequencer #(.NR_128(10), .NR_192(12), .NR_256(14), .RIDX_W(RIDX_W)) dut (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
      .mode(mode), .key_size(key_size), .abort(abort), .load(load), .key_step(key_step),
      .key_dir(key_dir), .init_ark(init_ark), .round_en(round_en), .last_round(last_round),
      .inv(inv), .round_idx(round_idx), .busy(busy), .out_valid(out_valid),
      .out_ready(out_ready), .err(err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_miss = 0;
   int cyc = 0;

   bit m_active = 0;
   bit m_inv = 0;
   bit m_err = 0;
   int m_k = 0;
   int m_nr = 0;

   function automatic int nr_of(input logic [1:0] ks);
      case (ks)
         2'b00:   return 10;
         2'b01:   return 12;
         default: return 14;
      endcase
   endfunction

   function automatic int done_k(input bit dec, input int nr);
      return dec ? 2 * nr + 2 : nr + 2;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
      end
   endtask

   // Model: a job is just its offset k from the acceptance edge, its direction and Nr
   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_active = 0;
         m_err    = 0;
      end else if (!m_active) begin
         m_err = start_valid && key_size == 2'b11;
         if (start_valid && key_size != 2'b11) begin
            m_active = 1;
            m_k      = 1;
            m_inv    = mode;
            m_nr     = nr_of(key_size);
         end
      end else begin
         m_err = 0;
         if (abort) m_active = 0;
         else if (m_k >= done_k(m_inv, m_nr)) begin
            if (out_ready) m_active = 0;
         end else m_k++;
      end
   end

   always @(negedge clk) begin : cmp
      bit e_sr, e_ld, e_ks, e_ia, e_re, e_lr, e_bs, e_ov, e_er, kd_chk, e_kd;
      int e_idx, nr, k;
      logic [12:0] exp_bus, got_bus;
      e_sr = 0; e_ld = 0; e_ks = 0; e_ia = 0; e_re = 0; e_lr = 0; e_bs = 0; e_ov = 0; e_er = 0;
      kd_chk = 0; e_kd = 0; e_idx = 0; nr = m_nr; k = m_k;
      if (!rst_n) begin
         kd_chk = 1;
         chk("inv_in_reset", inv, 0);
      end else if (!m_active) begin
         e_sr   = 1;
         e_ld   = start_valid && key_size != 2'b11;
         e_er   = m_err;
         kd_chk = 1;
      end else begin
         e_bs = 1;
         if (m_inv) begin
            if (k <= nr) begin
               e_ks = 1; e_idx = k; kd_chk = 1; e_kd = 0;
            end else if (k == nr + 1) begin
               e_ia = 1; e_idx = nr;
            end else if (k <= 2 * nr + 1) begin
               e_re = 1; e_ks = 1; e_idx = 2 * nr + 1 - k; e_lr = (k == 2 * nr + 1);
               kd_chk = 1; e_kd = 1;
            end else begin
               e_ov = 1; e_idx = 0;
            end
         end else begin
            if (k == 1) begin
               e_ia = 1; e_idx = 0;
            end else if (k <= nr + 1) begin
               e_re = 1; e_ks = 1; e_idx = k - 1; e_lr = (k == nr + 1);
               kd_chk = 1; e_kd = 0;
            end else begin
               e_ov = 1; e_idx = nr;
            end
         end
         chk("inv", inv, m_inv);
      end
      exp_bus = {e_sr, e_ld, e_ks, e_ia, e_re, e_lr, e_bs, e_ov, e_er, RIDX_W'(e_idx)};
      got_bus = {start_ready, load, key_step, init_ark, round_en, last_round, busy, out_valid,
                 err, round_idx};
      chk("outputs{srdy,load,kstep,iark,ren,last,busy,ovld,err,idx}", got_bus, exp_bus);
      if (kd_chk) chk("key_dir", key_dir, e_kd);
      chk("strobe_exclusive", ($countones({load, init_ark, round_en}) <= 1), 1);
   end

   // Called at #1 into the cycle in which the request is presented (cycle 0).
   task automatic do_job(input bit m, input logic [1:0] ks, input int hold, input int abort_at,
                         output int lat, output int ic, output int ii);
      int nr;
      nr = nr_of(ks);
      ic = -1;
      ii = -1;
      start_valid = 1; mode = m; key_size = ks;
      abort = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      start_valid = 0; abort = 0; out_ready = 0;
      lat = 1;
      while (!out_valid) begin
         if (init_ark && ic < 0) begin
            ic = lat;
            ii = int'(round_idx);
         end
         if (lat == abort_at) begin
            abort = 1;
            @(posedge clk); #1;
            abort = 0; start_valid = 0;
            chk("abort_busy", busy, 0);
            chk("abort_out_valid", out_valid, 0);
            lat = -1;
            return;
         end
         if (lat >= 200) begin
            chk("out_valid_timeout", out_valid, 1);
            lat = -1;
            return;
         end
         start_valid = 1'($urandom_range(0, 1));
         mode = 1'($urandom_range(0, 1));
         key_size = 2'($urandom_range(0, 3));
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, m ? 2 * nr + 2 : nr + 2);
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_idx", round_idx, m ? 0 : nr);
         @(posedge clk); #1;
      end
      out_ready = 1;
      start_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      out_ready = 0; start_valid = 0;
      chk("post_handshake_busy", busy, 0);
   endtask

   task automatic req_reserved();
      start_valid = 1; key_size = 2'b11; mode = 1'($urandom_range(0, 1));
      #1;
      chk("rsv_load", load, 0);
      @(posedge clk); #1;
      start_valid = 0;
      chk("rsv_err", err, 1);
      chk("rsv_busy", busy, 0);
      @(posedge clk); #1;
      chk("rsv_err_pulse", err, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int lat, ic, ii, ks, hold, ab;
      bit m;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_ready", start_ready, 0);
      chk("reset_idx", round_idx, 0);
      rst_n = 1;
      @(posedge clk); #1;
      chk("idle_ready", start_ready, 1);

      do_job(0, 2'b00, 0, 0, lat, ic, ii);
      chk("enc128_lat", lat, 12);
      chk("enc128_init_cycle", ic, 1);
      chk("enc128_init_idx", ii, 0);

      do_job(1, 2'b10, 0, 0, lat, ic, ii);
      chk("dec256_lat", lat, 30);
      chk("dec256_init_cycle", ic, 15);
      chk("dec256_init_idx", ii, 14);

      do_job(0, 2'b01, 5, 0, lat, ic, ii);
      chk("enc192_lat", lat, 14);
      chk("enc192_ready_after", start_ready, 1);

      req_reserved();
      do_job(1, 2'b00, 1, 0, lat, ic, ii);
      chk("dec128_after_rsv_lat", lat, 22);

      do_job(0, 2'b00, 0, 5, lat, ic, ii);
      chk("abort_ready", start_ready, 1);
      do_job(0, 2'b00, 0, 0, lat, ic, ii);
      chk("after_abort_lat", lat, 12);

      start_valid = 1; mode = 0; key_size = 2'b00;
      @(posedge clk); #1;
      start_valid = 0;
      repeat (4) begin @(posedge clk); #1; end
      chk("pre_reset_round_en", round_en, 1);
      rst_n = 0; start_valid = 1;
      #1;
      chk("in_reset_ready", start_ready, 0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("in_reset_ready", start_ready, 0);
         chk("in_reset_busy", busy, 0);
         chk("in_reset_round_en", round_en, 0);
      end
      rst_n = 1; start_valid = 0;
      @(posedge clk); #1;
      chk("release_ready", start_ready, 1);
      chk("release_busy", busy, 0);

      for (int j = 0; j < 40; j++) begin
         ks = $urandom_range(0, 3);
         if (ks == 3) req_reserved();
         else begin
            m = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 3);
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 30) : 0;
            do_job(m, 2'(ks), hold, ab, lat, ic, ii);
         end
         repeat ($urandom_range(0, 2)) begin
            start_valid = 0;
            abort = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         abort = 0;
      end

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
